mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter N_CH, default 2: number of requester channels, legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter MAX_BURST, default 4: maximum consecutive beats granted to one channel while any other channel is requesting; legal range 1..15.
REQ-005 The block SHALL have one clock, HCLK, and an asynchronous, active-high reset, HRESET.
REQ-006 Port HCLK, input, 1: clock; all logic is on the rising edge.
REQ-007 Port HRESET, input, 1: asynchronous, active-high reset.
REQ-008 Port ch_req, input, N_CH: per-channel access request, one beat per cycle.
REQ-009 Port ch_we, input, N_CH: per-channel direction; 1 = write, 0 = read.
REQ-010 Port ch_addr, input, N_CH*ADDR_W: per-channel address, packed with channel 0 in the LSBs.
REQ-011 Port ch_wdata, input, N_CH*DATA_W: per-channel write data, packed with channel 0 in the LSBs.
REQ-012 Port ch_gnt, output, N_CH: one-hot, combinational beat accepted this cycle.
REQ-013 Port ch_rvalid, output, N_CH: one-hot read data valid.
REQ-014 Port ch_rdata, output, DATA_W: read data, qualified by ch_rvalid.
REQ-015 Port mem_addr, output, ADDR_W: memory address.
REQ-016 Port mem_read_flag, output, 1: memory read strobe.
REQ-017 Port mem_write_flag, output, 1: memory write strobe.
REQ-018 Port mem_wdata, output, DATA_W: memory write data.
REQ-019 Port mem_rdata, input, DATA_W: memory read data, valid one cycle after mem_read_flag.

Function
REQ-020 At most one ch_gnt bit SHALL be high in any cycle; a beat transfers when ch_req[i] and ch_gnt[i] are both high.
REQ-021 The memory strobes SHALL be combinational from the granted channel: mem_read_flag = granted & ~we, mem_write_flag = granted & we; mem_addr and mem_wdata come from the granted channel; when nothing is granted, all strobes and data are 0.
REQ-022 The state machine SHALL have two states. IDLE: no owner. OWN: owner register holds the channel index and beat counter holds the beats granted.
REQ-023 From IDLE, the lowest-index requester at or after rr_ptr (cyclic) SHALL be granted in the same cycle; the next state is OWN with owner = that channel and beat_cnt = 1.
REQ-024 In OWN, the owner SHALL keep the grant while ch_req[owner] is high and either beat_cnt < MAX_BURST or no other channel is requesting; beat_cnt saturates at MAX_BURST.
REQ-025 In OWN, if the owner drops its request, or reaches MAX_BURST while another channel is requesting, the arbiter SHALL re-arbitrate in the same cycle, excluding the owner; rr_ptr becomes owner+1 mod N_CH; if no other channel is requesting, the next state is IDLE.
REQ-026 Read return: ch_rvalid[k] SHALL be asserted exactly one cycle after a read beat from channel k, with ch_rdata = mem_rdata; a read-tag register carries k and a valid bit.
REQ-027 Back-to-back reads from different channels SHALL each return in order, one per cycle, with no bubble.
REQ-028 A write followed by a read to the same address on the next cycle SHALL return the written data; memory ordering provides this, and the arbiter SHALL NOT reorder beats.
REQ-029 If ch_req changes while not granted, there SHALL be no effect on the current owner.

Reset
REQ-030 On HRESET: state = IDLE, rr_ptr = 0, beat_cnt = 0, read-tag valid = 0, and ch_gnt, ch_rvalid, mem_read_flag and mem_write_flag = 0.
REQ-031 A reset during a read beat SHALL suppress that beat's ch_rvalid.

Configuration
REQ-032 With MEM_ARB_STATS_EN defined, the block SHALL add output grant_cnt of width N_CH*16: a per-channel count of granted beats that saturates at 16'hFFFF and is cleared by HRESET.
REQ-033 Without MEM_ARB_STATS_EN, the port and the counters SHALL be absent.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum arb_state_e (ARB_IDLE, ARB_OWN), the MAX_N_CH constant of 8, and a function that selects the next index cyclically from a request vector and a pointer.
REQ-035 Sub-module rr_picker SHALL be natural: a combinational round-robin select of (req, ptr, mask) that outputs a one-hot grant and an index.

Verification
REQ-036 Reset release with no requests -> all outputs 0 and state IDLE.
REQ-037 N_CH=2: ch0 read to 0x10 and ch1 write of 0xA5 to 0x20 in the same cycle, rr_ptr=0 -> ch0 granted first, ch_rvalid[0] one cycle later, then ch1 write.
REQ-038 MAX_BURST=4: ch0 and ch1 both request continuously -> grant pattern 0,0,0,0,1,1,1,1,0 and so on.
REQ-039 Only ch1 requests 10 beats -> all 10 beats granted with no rotation gap.
REQ-040 ch0 writes 0x1234 to 0x40, then ch1 reads 0x40 on the next cycle -> ch_rvalid[1] with ch_rdata = 0x1234.
REQ-041 HRESET asserted in the same cycle as a read grant -> no ch_rvalid afterwards; with MEM_ARB_STATS_EN, grant_cnt returns to 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory port arbiter.
//   arb_state_e  - arbiter state (ARB_IDLE, ARB_OWN)
//   MAX_N_CH     - largest supported channel count
//   IDX_W        - width of a channel index
//   rr_pick_idx  - cyclic "first requester at or after ptr" search
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_N_CH = 8;
    localparam int unsigned IDX_W    = 3;

    // Returns the lowest index at or after ptr (wrapping at n_ch) whose req bit is set.
    // Returns 0 when nothing is requesting; callers qualify with |req.
    function automatic logic [IDX_W-1:0] rr_pick_idx(
        input logic [MAX_N_CH-1:0] req,
        input logic [IDX_W-1:0]    ptr,
        input int unsigned         n_ch
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        int unsigned      c;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_N_CH; k++) begin
            c = (32'(ptr) + k) % n_ch;
            if (!found && (k < n_ch) && req[c[IDX_W-1:0]]) begin
                idx   = c[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req   - request vector
//   ptr   - highest-priority index for this pick
//   mask  - eligibility mask (1 = may be picked)
//   gnt   - one-hot pick (all zero when nothing eligible)
//   idx   - index of the pick
//   valid - something was picked
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_CH = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N_CH-1:0]  mask,
    output logic [N_CH-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [MAX_N_CH-1:0] req_pad;

    always_comb begin
        req_pad             = '0;
        req_pad[N_CH-1:0]   = req & mask;
        valid               = |req_pad;
        idx                 = rr_pick_idx(req_pad, ptr, N_CH);
        gnt                 = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            gnt[i] = valid && (idx == i[IDX_W-1:0]);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port among N_CH channels,
// with burst limiting (MAX_BURST beats while others wait) and one-cycle read return.
// Ports:
//   HCLK, HRESET                   - clock, async active-high reset
//   ch_req/ch_we/ch_addr/ch_wdata  - per-channel request, direction, address, write data
//   ch_gnt                         - one-hot combinational beat accept
//   ch_rvalid/ch_rdata             - read return, one cycle after the read beat
//   mem_addr/mem_read_flag/mem_write_flag/mem_wdata/mem_rdata - memory side
//   grant_cnt                      - per-channel saturating beat counts (MEM_ARB_STATS_EN only)
// Optional feature macro: MEM_ARB_STATS_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [N_CH-1:0]        ch_req,
    input  logic [N_CH-1:0]        ch_we,
    input  logic [N_CH*ADDR_W-1:0] ch_addr,
    input  logic [N_CH*DATA_W-1:0] ch_wdata,
    output logic [N_CH-1:0]        ch_gnt,
    output logic [N_CH-1:0]        ch_rvalid,
    output logic [DATA_W-1:0]      ch_rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_read_flag,
    output logic                   mem_write_flag,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [N_CH*16-1:0]     grant_cnt
`endif
);

    localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             rtag_valid_q, rtag_valid_d;
    logic [IDX_W-1:0] rtag_ch_q, rtag_ch_d;

    logic [N_CH-1:0]  owner_oh;
    logic [IDX_W-1:0] owner_next;
    logic             others_req;
    logic             keep;

    logic [IDX_W-1:0] pick_ptr;
    logic [N_CH-1:0]  pick_mask;
    logic [N_CH-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    logic [IDX_W-1:0] gnt_idx;
    logic             granted;

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            owner_oh[i] = (owner_q == i[IDX_W-1:0]);
        end
        owner_next = (32'(owner_q) == N_CH - 1) ? '0 : owner_q + IDX_W'(1);
        others_req = |(ch_req & ~owner_oh);
        keep       = ch_req[owner_q] && ((beat_cnt_q < MaxBurst) || !others_req);
    end

    // In OWN the picker only runs for re-arbitration, which always excludes the owner.
    always_comb begin
        pick_ptr  = rr_ptr_q;
        pick_mask = '1;
        if (state_q == ARB_OWN) begin
            pick_ptr  = owner_next;
            pick_mask = ~owner_oh;
        end
    end

    rr_picker #(
        .N_CH (N_CH)
    ) u_picker (
        .req   (ch_req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        ch_gnt     = '0;
        gnt_idx    = owner_q;
        granted    = 1'b0;
        // Grants are held off while reset is asserted so no beat can slip through.
        if (!HRESET) begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        ch_gnt     = pick_gnt;
                        gnt_idx    = pick_idx;
                        granted    = 1'b1;
                        state_d    = ARB_OWN;
                        owner_d    = pick_idx;
                        beat_cnt_d = 4'd1;
                    end
                end
                ARB_OWN: begin
                    if (keep) begin
                        ch_gnt  = owner_oh;
                        granted = 1'b1;
                        if (beat_cnt_q < MaxBurst) begin
                            beat_cnt_d = beat_cnt_q + 4'd1;
                        end
                    end else begin
                        rr_ptr_d = owner_next;
                        if (pick_valid) begin
                            ch_gnt     = pick_gnt;
                            gnt_idx    = pick_idx;
                            granted    = 1'b1;
                            owner_d    = pick_idx;
                            beat_cnt_d = 4'd1;
                        end else begin
                            state_d    = ARB_IDLE;
                            beat_cnt_d = 4'd0;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_read_flag  = 1'b0;
        mem_write_flag = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (ch_gnt[i]) begin
                mem_addr       = ch_addr[i*ADDR_W +: ADDR_W];
                mem_wdata      = ch_wdata[i*DATA_W +: DATA_W];
                mem_read_flag  = ~ch_we[i];
                mem_write_flag = ch_we[i];
            end
        end
        rtag_valid_d = granted && mem_read_flag;
        rtag_ch_d    = gnt_idx;
    end

    always_comb begin
        ch_rvalid = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            ch_rvalid[i] = rtag_valid_q && (rtag_ch_q == i[IDX_W-1:0]);
        end
        ch_rdata = rtag_valid_q ? mem_rdata : '0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            rr_ptr_q     <= '0;
            rtag_valid_q <= 1'b0;
            rtag_ch_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            rtag_valid_q <= rtag_valid_d;
            rtag_ch_q    <= rtag_ch_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] grant_cnt_q [N_CH];
    logic [15:0] grant_cnt_d [N_CH];

    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (ch_gnt[i] && ch_req[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
            end
            grant_cnt[i*16 +: 16] = grant_cnt_q[i];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                grant_cnt_q[i] <= grant_cnt_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
// (N_CH=2, 32-bit address/data, MAX_BURST=4) with a small behavioural memory.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [1:0]  ch_req;
    logic [1:0]  ch_we;
    logic [63:0] ch_addr;
    logic [63:0] ch_wdata;
    logic [1:0]  ch_gnt;
    logic [1:0]  ch_rvalid;
    logic [31:0] ch_rdata;
    logic [31:0] mem_addr;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];

    mem_port_arbiter #(
        .N_CH      (2),
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_BURST (4)
    ) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .ch_req         (ch_req),
        .ch_we          (ch_we),
        .ch_addr        (ch_addr),
        .ch_wdata       (ch_wdata),
        .ch_gnt         (ch_gnt),
        .ch_rvalid      (ch_rvalid),
        .ch_rdata       (ch_rdata),
        .mem_addr       (mem_addr),
        .mem_read_flag  (mem_read_flag),
        .mem_write_flag (mem_write_flag),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_cnt      (grant_cnt)
`endif
    );

    always #5 HCLK = ~HCLK;

    // Memory with write-first storage and one-cycle read latency.
    always @(posedge HCLK) begin
        if (mem_write_flag) begin
            mem[mem_addr] = mem_wdata;
        end
        if (mem_read_flag) begin
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        end else begin
            mem_rdata <= 32'h0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive at the falling edge, then look 1ns later, well clear of the rising edge.
    task automatic cycle(input logic [1:0] req, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(negedge HCLK);
        ch_req   = req;
        ch_we    = we;
        ch_addr  = {a1, a0};
        ch_wdata = {d1, d0};
        #1;
    endtask

    logic [1:0] burst_exp [9];

    initial begin
        HRESET   = 1'b1;
        ch_req   = '0;
        ch_we    = '0;
        ch_addr  = '0;
        ch_wdata = '0;
        mem[32'h10] = 32'hDEAD_0010;
        burst_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

        // Reset release, no requests
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        cycle(2'b00, 2'b00, 0, 0, 0, 0);
        check_eq("rst_gnt", ch_gnt, 2'b00);
        check_eq("rst_rvalid", ch_rvalid, 2'b00);
        check_eq("rst_rd", mem_read_flag, 1'b0);
        check_eq("rst_wr", mem_write_flag, 1'b0);
        check_eq("rst_addr", mem_addr, 32'h0);
        check_eq("rst_rdata", ch_rdata, 32'h0);
        check_eq("rst_state", dut.state_q, ARB_IDLE);
`ifdef MEM_ARB_STATS_EN
        check_eq("rst_cnt", grant_cnt, 32'h0);
`endif

        // ch0 read 0x10 and ch1 write 0xA5 to 0x20 together
        cycle(2'b11, 2'b10, 32'h10, 32'h20, 32'h0, 32'hA5);
        check_eq("rw_gnt0", ch_gnt, 2'b01);
        check_eq("rw_rd0", mem_read_flag, 1'b1);
        check_eq("rw_wr0", mem_write_flag, 1'b0);
        check_eq("rw_addr0", mem_addr, 32'h10);
        cycle(2'b10, 2'b10, 32'h10, 32'h20, 32'h0, 32'hA5);
        check_eq("rw_rvalid0", ch_rvalid, 2'b01);
        check_eq("rw_rdata0", ch_rdata, 32'hDEAD_0010);
        check_eq("rw_gnt1", ch_gnt, 2'b10);
        check_eq("rw_wr1", mem_write_flag, 1'b1);
        check_eq("rw_addr1", mem_addr, 32'h20);
        check_eq("rw_wdata1", mem_wdata, 32'hA5);
        cycle(2'b00, 2'b00, 0, 0, 0, 0);
        check_eq("rw_gnt_end", ch_gnt, 2'b00);
        check_eq("rw_rvalid_end", ch_rvalid, 2'b00);

        // Both request continuously: 4 beats each, alternating
        for (int k = 0; k < 9; k++) begin
            cycle(2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
            check_eq($sformatf("burst_gnt%0d", k), ch_gnt, burst_exp[k]);
        end
        cycle(2'b00, 2'b00, 0, 0, 0, 0);

        // Lone requester ch1: 10 beats, no gaps
        for (int k = 0; k < 10; k++) begin
            cycle(2'b10, 2'b10, 0, 32'h100 + k, 0, 32'h5000 + k);
            check_eq($sformatf("solo_gnt%0d", k), ch_gnt, 2'b10);
        end
        cycle(2'b00, 2'b00, 0, 0, 0, 0);
        check_eq("solo_idle_gnt", ch_gnt, 2'b00);

        // Write 0x1234 to 0x40 from ch0, ch1 reads it back next cycle
        cycle(2'b01, 2'b01, 32'h40, 0, 32'h1234, 0);
        check_eq("wr_gnt", ch_gnt, 2'b01);
        check_eq("wr_flag", mem_write_flag, 1'b1);
        cycle(2'b10, 2'b00, 0, 32'h40, 0, 0);
        check_eq("rd_gnt", ch_gnt, 2'b10);
        check_eq("rd_flag", mem_read_flag, 1'b1);
        check_eq("rd_addr", mem_addr, 32'h40);
        cycle(2'b00, 2'b00, 0, 0, 0, 0);
        check_eq("raw_rvalid", ch_rvalid, 2'b10);
        check_eq("raw_rdata", ch_rdata, 32'h1234);
`ifdef MEM_ARB_STATS_EN
        check_eq("cnt_ch0", grant_cnt[15:0], 16'd7);
        check_eq("cnt_ch1", grant_cnt[31:16], 16'd16);
`endif

        // Reset asserted during a read grant
        cycle(2'b01, 2'b00, 32'h10, 0, 0, 0);
        check_eq("rr_gnt", ch_gnt, 2'b01);
        check_eq("rr_rd", mem_read_flag, 1'b1);
        #2;
        HRESET = 1'b1;
        #1;
        check_eq("rr_gnt_inrst", ch_gnt, 2'b00);
        check_eq("rr_rd_inrst", mem_read_flag, 1'b0);
        cycle(2'b00, 2'b00, 0, 0, 0, 0);
        check_eq("rr_rvalid_a", ch_rvalid, 2'b00);
        HRESET = 1'b0;
        cycle(2'b00, 2'b00, 0, 0, 0, 0);
        check_eq("rr_rvalid_b", ch_rvalid, 2'b00);
        check_eq("rr_state", dut.state_q, ARB_IDLE);
`ifdef MEM_ARB_STATS_EN
        check_eq("rr_cnt", grant_cnt, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
